// File: rtl/packet_buffer_streamer.sv
// packet_buffer_streamer
// Reads a (start address, length) byte run out of the packet-buffer BRAM and
// presents it as a valid/ready byte stream with out_last on the final byte.
// Reads are credit-limited so returned data always fits in the output FIFO.
module packet_buffer_streamer #(
  parameter int RAM_SIZE_LOG2 = 11,
  parameter int LEN_W         = 12,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [RAM_SIZE_LOG2-1:0] cmd_addr,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     read_req,
  output logic [RAM_SIZE_LOG2-1:0] read_addr,
  input  logic                     read_ready,
  input  logic [7:0]               read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic                     busy
);

  // Counter width covers both the FIFO occupancy and the in-flight read count.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                   state_q,      state_d;
  logic                     cmd_ready_q,  cmd_ready_d;
  logic                     busy_q,       busy_d;
  logic [RAM_SIZE_LOG2-1:0] issue_addr_q, issue_addr_d;
  logic [LEN_W-1:0]         issue_rem_q,  issue_rem_d;
  logic [LEN_W-1:0]         emit_rem_q,   emit_rem_d;
  logic                     read_req_q,   read_req_d;
  logic [RAM_SIZE_LOG2-1:0] read_addr_q,  read_addr_d;
  logic [CNT_W-1:0]         in_flight_q,  in_flight_d;
  logic [CNT_W-1:0]         fifo_cnt_q,   fifo_cnt_d;
  logic [PTR_W-1:0]         wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q,     rd_ptr_d;
  logic [7:0]               fifo_mem_q [FIFO_DEPTH];
  logic [7:0]               fifo_mem_d [FIFO_DEPTH];

  logic                     accept;
  logic                     start;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic                     last_xfer;
  logic [RAM_SIZE_LOG2-1:0] src_addr;
  logic [LEN_W-1:0]         src_rem;
  logic [CNT_W-1:0]         credit_used;

  // Output stream is the FIFO head; last is flagged from the emit counter.
  assign out_valid = (fifo_cnt_q != CNT_ZERO);
  assign out_data  = fifo_mem_q[rd_ptr_q];
  assign out_last  = out_valid & (emit_rem_q == LEN_ONE);
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign read_req  = read_req_q;
  assign read_addr = read_addr_q;

  // Next-state logic: command accept, credit-gated read issue, FIFO and counters.
  // The first read is issued on the accept edge itself, straight from cmd_addr,
  // so the first byte reaches the output READ_LATENCY+1 cycles after accept.
  // A byte popped this cycle returns its credit immediately, which keeps the
  // stream at one byte per cycle with a FIFO only READ_LATENCY+2 deep.
  always_comb begin
    accept      = cmd_valid & cmd_ready_q;
    start       = accept & (cmd_len != '0);
    pop         = out_valid & out_ready;
    push        = read_ready & (state_q != IDLE) & (in_flight_q != CNT_ZERO);
    last_xfer   = pop & (emit_rem_q == LEN_ONE);
    src_addr    = start ? cmd_addr : issue_addr_q;
    src_rem     = start ? cmd_len : issue_rem_q;
    credit_used = in_flight_q + fifo_cnt_q - (pop ? CNT_ONE : CNT_ZERO);
    issue       = (start | (state_q == ISSUE)) & (src_rem != '0) &
                  (credit_used < DEPTH_C);

    read_req_d   = issue;
    read_addr_d  = issue ? src_addr : read_addr_q;
    issue_addr_d = issue ? (src_addr + RAM_SIZE_LOG2'(1)) : src_addr;
    issue_rem_d  = issue ? (src_rem - LEN_ONE) : src_rem;

    emit_rem_d = emit_rem_q;
    if (start) begin
      emit_rem_d = cmd_len;
    end else if (pop && (emit_rem_q != '0)) begin
      emit_rem_d = emit_rem_q - LEN_ONE;
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (issue_rem_d == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (last_xfer) begin
          state_d = IDLE;
        end else if (issue_rem_d == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);

    in_flight_d = in_flight_q + (issue ? CNT_ONE : CNT_ZERO)
                              - (push ? CNT_ONE : CNT_ZERO);

    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = read_data;
    end
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + (push ? CNT_ONE : CNT_ZERO)
                            - (pop ? CNT_ONE : CNT_ZERO);
  end

  // State register: reset aborts any packet and discards FIFO and in-flight reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      issue_addr_q <= '0;
      issue_rem_q  <= '0;
      emit_rem_q   <= '0;
      read_req_q   <= 1'b0;
      read_addr_q  <= '0;
      in_flight_q  <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      issue_addr_q <= issue_addr_d;
      issue_rem_q  <= issue_rem_d;
      emit_rem_q   <= emit_rem_d;
      read_req_q   <= read_req_d;
      read_addr_q  <= read_addr_d;
      in_flight_q  <= in_flight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_mem_q   <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_packet_buffer_streamer.sv
// tb_packet_buffer_streamer
// Directed bench: a two-stage BRAM model returns mem[n] = n[7:0]; a negedge
// monitor records stream transfers and read addresses for comparison.
module tb_packet_buffer_streamer;

  localparam int AW = 11;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          read_req;
  logic [AW-1:0] read_addr;
  logic          read_ready;
  logic [7:0]    read_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;
  logic          inject_ready = 1'b0;

  packet_buffer_streamer #(
    .RAM_SIZE_LOG2(AW),
    .LEN_W(LW),
    .READ_LATENCY(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .read_req(read_req),
    .read_addr(read_addr),
    .read_ready(read_ready),
    .read_data(read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM model: read_ready/read_data follow read_req/read_addr by two cycles.
  logic          p1_req, p2_req;
  logic [AW-1:0] p1_addr, p2_addr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_req  <= 1'b0;
      p2_req  <= 1'b0;
      p1_addr <= '0;
      p2_addr <= '0;
    end else begin
      p1_req  <= read_req;
      p1_addr <= read_addr;
      p2_req  <= p1_req;
      p2_addr <= p1_addr;
    end
  end
  assign read_ready = p2_req | inject_ready;
  assign read_data  = p2_addr[7:0];

  int cycle = 0;
  always @(posedge clk) cycle++;

  int            compared = 0;
  int            mismatched = 0;
  int            accept_cycle = 0;
  logic [7:0]    q_data [$];
  logic          q_last [$];
  int            q_cyc [$];
  logic [AW-1:0] ra_q [$];
  bit            first_seen = 1'b0;
  int            first_cycle = 0;
  int            valid_count = 0;
  int            stab_err = 0;
  bit            prev_stall = 1'b0;
  logic [7:0]    prev_data = '0;

  // Monitor away from the active edge: transfers, issued reads, stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data != prev_data)) stab_err++;
      if (out_valid) begin
        valid_count++;
        if (!first_seen) begin
          first_seen  = 1'b1;
          first_cycle = cycle;
        end
      end
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_cyc.push_back(cycle);
      end
      if (read_req) ra_q.push_back(read_addr);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [7:0]    first;
    logic [7:0]    last;
    int            latency;
    int            span;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_monitor();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    ra_q.delete();
    first_seen  = 1'b0;
    valid_count = 0;
    stab_err    = 0;
  endtask

  task automatic apply_stimulus(input logic [AW-1:0] addr, input int len);
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cycle = cycle;
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({name, "_read_req"},  32'(read_req),  32'd0);
    check({name, "_read_addr"}, 32'(read_addr), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_data"},  32'(out_data),  32'd0);
    check({name, "_out_last"},  32'(out_last),  32'd0);
    check({name, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic check_output(input string name, input logic [AW-1:0] addr, input int len,
                              input int latency, input int span);
    logic [AW-1:0] a;
    check({name, "_count"}, 32'(q_data.size()), 32'(len));
    check({name, "_reads"}, 32'(ra_q.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      a = addr + AW'(i);
      if (i < q_data.size()) begin
        check($sformatf("%s_data%0d", name, i), 32'(q_data[i]), 32'(a[7:0]));
        check($sformatf("%s_last%0d", name, i), 32'(q_last[i]), 32'(i == len - 1));
      end
      if (i < ra_q.size()) begin
        check($sformatf("%s_raddr%0d", name, i), 32'(ra_q[i]), 32'(a));
      end
    end
    check({name, "_latency"}, 32'(first_cycle - accept_cycle), 32'(latency));
    if (span >= 0 && q_cyc.size() == len) begin
      check({name, "_span"}, 32'(q_cyc[len-1] - q_cyc[0]), 32'(span));
    end
    check({name, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got;

    vecs[0] = '{11'h010,  4, 8'h10, 8'h13, 3,  3};
    vecs[1] = '{11'h7FE,  4, 8'hFE, 8'h01, 3,  3};
    vecs[2] = '{11'h020,  1, 8'h20, 8'h20, 3,  0};
    vecs[3] = '{11'h0F0, 20, 8'hF0, 8'h03, 3, 19};
    vecs[4] = '{11'h7FF,  2, 8'hFF, 8'h00, 3,  1};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven commands with the sink always ready.
    for (int v = 0; v < 5; v++) begin
      clear_monitor();
      out_ready = 1'b1;
      apply_stimulus(vecs[v].addr, vecs[v].len);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      wait_done($sformatf("vec%0d", v), 100);
      if (q_data.size() == vecs[v].len) begin
        check($sformatf("vec%0d_first", v), 32'(q_data[0]), 32'(vecs[v].first));
        check($sformatf("vec%0d_lastbyte", v), 32'(q_data[vecs[v].len-1]), 32'(vecs[v].last));
      end
      check_output($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len,
                   vecs[v].latency, vecs[v].span);
    end

    // Sink stalled for 10 cycles: credits stop issue at four reads.
    clear_monitor();
    out_ready = 1'b0;
    apply_stimulus(11'h140, 8);
    repeat (10) @(posedge clk);
    #1;
    check("stall_reads", 32'(ra_q.size()), 32'd4);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_head",  32'(out_data),  32'h40);
    check("stall_last",  32'(out_last),  32'd0);
    out_ready = 1'b1;
    wait_done("stall", 100);
    check_output("stall", 11'h140, 8, 3, -1);

    // Sink ready toggling every cycle.
    clear_monitor();
    out_ready = 1'b1;
    apply_stimulus(11'h030, 6);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin
        got = 1'b1;
        break;
      end
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    check("toggle_done", 32'(got), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("toggle", 11'h030, 6, 3, -1);

    // Zero-length command followed immediately by a single-byte command.
    clear_monitor();
    apply_stimulus(11'h055, 0);
    check("len0_busy",  32'(busy),      32'd0);
    check("len0_ready", 32'(cmd_ready), 32'd1);
    apply_stimulus(11'h020, 1);
    check("len0_noreads", 32'(ra_q.size()),  32'd0);
    check("len0_novalid", 32'(valid_count),  32'd0);
    check("len1_busy",    32'(busy),         32'd1);
    wait_done("len1", 50);
    check_output("len1", 11'h020, 1, 3, 0);

    // Spurious read_ready while idle must be ignored.
    clear_monitor();
    inject_ready = 1'b1;
    @(posedge clk);
    #1;
    inject_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_pulse_novalid", 32'(valid_count), 32'd0);
    check("idle_pulse_busy",    32'(busy),        32'd0);
    clear_monitor();
    apply_stimulus(11'h0AB, 2);
    wait_done("idle_pulse", 50);
    check_output("idle_pulse", 11'h0AB, 2, 3, 1);

    // Reset asserted while byte 3 of a 16-byte packet is on the output.
    clear_monitor();
    out_ready = 1'b1;
    apply_stimulus(11'h200, 16);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (q_data.size() >= 2) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("midreset_reached", 32'(got), 32'd1);
    check("midreset_byte3", 32'(out_data), 32'h02);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_monitor();
    repeat (8) @(posedge clk);
    #1;
    check("postreset_novalid", 32'(valid_count), 32'd0);
    check("postreset_noreads", 32'(ra_q.size()),  32'd0);
    clear_monitor();
    apply_stimulus(11'h300, 2);
    wait_done("postreset", 50);
    check_output("postreset", 11'h300, 2, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
